// File: rtl/wishbone_top.sv
// wishbone_top
// Wishbone B4 classic subsystem: a single-transfer bus master feeding a
// 2^ADDR_WIDTH-word register-file slave over an internal bus.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   Request side : addr_o, data_o, we_o, stb_o, cyc_o, sel_o, cti_input, tag_add
//   Response side: ack_i, err_i (one-cycle pulses), data_i (last read data)
//   state_out    : master state (IDLE=00, BUSY=01, DONE=10, ERROR=11)
//   dbg_*        : internal bus signals
//   counter      : acknowledged beats in the current bus cycle
module wishbone_top #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0] data_o,
    input  logic                  we_o,
    input  logic                  stb_o,
    input  logic                  cyc_o,
    input  logic [SEL_WIDTH-1:0]  sel_o,
    input  logic [2:0]            cti_input,
    input  logic                  tag_add,
    output logic                  ack_i,
    output logic                  err_i,
    output logic [DATA_WIDTH-1:0] data_i,
    output logic [1:0]            state_out,
    output logic [ADDR_WIDTH-1:0] dbg_w_addr,
    output logic [DATA_WIDTH-1:0] dbg_w_data_m2s,
    output logic [DATA_WIDTH-1:0] dbg_w_data_s2m,
    output logic                  dbg_w_we,
    output logic                  dbg_tag_add,
    output logic [SEL_WIDTH-1:0]  dbg_w_sel,
    output logic                  dbg_w_stb,
    output logic                  dbg_w_cyc,
    output logic                  dbg_w_ack,
    output logic                  dbg_w_err,
    output logic [2:0]            dbg_cti,
    output logic [ADDR_WIDTH-1:0] counter
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } state_t;

    state_t state_q, state_d;

    // Master-side bus registers
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_m2s_q, w_data_m2s_d;
    logic                  w_we_q, w_we_d;
    logic [SEL_WIDTH-1:0]  w_sel_q, w_sel_d;
    logic [2:0]            w_cti_q, w_cti_d;
    logic                  w_tag_q, w_tag_d;
    logic                  w_stb_q, w_stb_d;
    logic                  cyc_reg_q, cyc_reg_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_i_q, data_i_d;

    // Slave-side registers
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  w_ack_q, w_ack_d;
    logic                  w_err_q, w_err_d;
    logic [DATA_WIDTH-1:0] w_data_s2m_q, w_data_s2m_d;
    logic [ADDR_WIDTH-1:0] counter_q, counter_d;

    // The bus cycle is forced high while a transfer is outstanding so a
    // falling cyc_o cannot cut a transfer short.
    logic w_cyc;
    assign w_cyc = (state_q == BUSY) | cyc_reg_q;

    // ---------------- Master FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- Master FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (stb_o) state_d = BUSY;
            BUSY: begin
                if (w_ack_q)      state_d = DONE;
                else if (w_err_q) state_d = ERROR;
            end
            DONE, ERROR: if (!stb_o) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // ---------------- Master FSM: outputs ----------------
    always_comb begin
        w_addr_d     = w_addr_q;
        w_data_m2s_d = w_data_m2s_q;
        w_we_d       = w_we_q;
        w_sel_d      = w_sel_q;
        w_cti_d      = w_cti_q;
        w_tag_d      = w_tag_q;
        w_stb_d      = w_stb_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        data_i_d     = data_i_q;
        cyc_reg_d    = cyc_o;
        case (state_q)
            IDLE: begin
                if (stb_o) begin
                    w_addr_d     = addr_o;
                    w_data_m2s_d = data_o;
                    w_we_d       = we_o;
                    w_sel_d      = sel_o;
                    w_cti_d      = cti_input;
                    w_tag_d      = tag_add;
                    w_stb_d      = 1'b1;
                end
            end
            BUSY: begin
                // Ack wins if both were ever seen; the slave never issues both.
                if (w_ack_q) begin
                    w_stb_d = 1'b0;
                    ack_d   = 1'b1;
                    if (!w_we_q) data_i_d = w_data_s2m_q;
                end else if (w_err_q) begin
                    w_stb_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_addr_q     <= '0;
            w_data_m2s_q <= '0;
            w_we_q       <= 1'b0;
            w_sel_q      <= '0;
            w_cti_q      <= '0;
            w_tag_q      <= 1'b0;
            w_stb_q      <= 1'b0;
            cyc_reg_q    <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            data_i_q     <= '0;
        end else begin
            w_addr_q     <= w_addr_d;
            w_data_m2s_q <= w_data_m2s_d;
            w_we_q       <= w_we_d;
            w_sel_q      <= w_sel_d;
            w_cti_q      <= w_cti_d;
            w_tag_q      <= w_tag_d;
            w_stb_q      <= w_stb_d;
            cyc_reg_q    <= cyc_reg_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            data_i_q     <= data_i_d;
        end
    end

    // ---------------- Slave register file ----------------
    // A new request is one not already answered by a response in flight.
    logic slv_req;
    logic slv_bad;
    assign slv_req = w_stb_q & w_cyc & ~w_ack_q & ~w_err_q;
    assign slv_bad = (w_sel_q == '0) | ((w_cti_q >= 3'd3) & (w_cti_q <= 3'd6));

    always_comb begin
        mem_d        = mem_q;
        w_ack_d      = 1'b0;
        w_err_d      = 1'b0;
        w_data_s2m_d = w_data_s2m_q;
        if (slv_req) begin
            if (slv_bad) begin
                w_err_d = 1'b1;
            end else begin
                w_ack_d = 1'b1;
                if (w_we_q) begin
                    for (int i = 0; i < SEL_WIDTH; i++) begin
                        if (w_sel_q[i]) mem_d[w_addr_q][8*i +: 8] = w_data_m2s_q[8*i +: 8];
                    end
                end else begin
                    w_data_s2m_d = mem_q[w_addr_q];
                end
            end
        end
    end

    // Beat counter restarts whenever the bus cycle envelope is down.
    always_comb begin
        counter_d = counter_q;
        if (!w_cyc)       counter_d = '0;
        else if (w_ack_q) counter_d = counter_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            w_ack_q      <= 1'b0;
            w_err_q      <= 1'b0;
            w_data_s2m_q <= '0;
            counter_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            w_ack_q      <= w_ack_d;
            w_err_q      <= w_err_d;
            w_data_s2m_q <= w_data_s2m_d;
            counter_q    <= counter_d;
        end
    end

    assign ack_i          = ack_q;
    assign err_i          = err_q;
    assign data_i         = data_i_q;
    assign state_out      = state_q;
    assign dbg_w_addr     = w_addr_q;
    assign dbg_w_data_m2s = w_data_m2s_q;
    assign dbg_w_data_s2m = w_data_s2m_q;
    assign dbg_w_we       = w_we_q;
    assign dbg_tag_add    = w_tag_q;
    assign dbg_w_sel      = w_sel_q;
    assign dbg_w_stb      = w_stb_q;
    assign dbg_w_cyc      = w_cyc;
    assign dbg_w_ack      = w_ack_q;
    assign dbg_w_err      = w_err_q;
    assign dbg_cti        = w_cti_q;
    assign counter        = counter_q;

endmodule

// File: tb/tb_wishbone_top.sv
// Testbench for wishbone_top: a transaction-timeline model predicts every
// output each cycle; directed transfers add literal expectations.
module tb_wishbone_top;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  addr_o;
    logic [31:0] data_o;
    logic        we_o, stb_o, cyc_o, tag_add;
    logic [3:0]  sel_o;
    logic [2:0]  cti_input;
    logic        ack_i, err_i;
    logic [31:0] data_i;
    logic [1:0]  state_out;
    logic [4:0]  dbg_w_addr;
    logic [31:0] dbg_w_data_m2s, dbg_w_data_s2m;
    logic        dbg_w_we, dbg_tag_add;
    logic [3:0]  dbg_w_sel;
    logic        dbg_w_stb, dbg_w_cyc, dbg_w_ack, dbg_w_err;
    logic [2:0]  dbg_cti;
    logic [4:0]  counter;

    int total = 0;
    int bad   = 0;

    wishbone_top dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_o(addr_o), .data_o(data_o), .we_o(we_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .sel_o(sel_o), .cti_input(cti_input),
        .tag_add(tag_add), .ack_i(ack_i), .err_i(err_i), .data_i(data_i),
        .state_out(state_out), .dbg_w_addr(dbg_w_addr), .dbg_w_data_m2s(dbg_w_data_m2s),
        .dbg_w_data_s2m(dbg_w_data_s2m), .dbg_w_we(dbg_w_we), .dbg_tag_add(dbg_tag_add),
        .dbg_w_sel(dbg_w_sel), .dbg_w_stb(dbg_w_stb), .dbg_w_cyc(dbg_w_cyc),
        .dbg_w_ack(dbg_w_ack), .dbg_w_err(dbg_w_err), .dbg_cti(dbg_cti), .counter(counter)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // ---------------- Model: one transfer timeline ----------------
    // m_age counts edges since the transfer was accepted (1 = request on bus,
    // 2 = slave response on bus, 3 = response delivered to requester).
    logic [31:0] m_mem [32];
    logic        m_active, m_cyc_reg;
    int          m_age;
    logic [4:0]  t_addr, m_cnt;
    logic [31:0] t_data, exp_data;
    logic        t_we, t_tag, t_bad, exp_ack, exp_err;
    logic [3:0]  t_sel;
    logic [2:0]  t_cti;

    logic e_wstb, e_wcyc, e_wack, e_werr;
    logic [1:0] e_state;
    assign e_wstb  = m_active && (m_age <= 2);
    assign e_wcyc  = e_wstb || m_cyc_reg;
    assign e_wack  = m_active && (m_age == 2) && !t_bad;
    assign e_werr  = m_active && (m_age == 2) && t_bad;
    assign e_state = !m_active ? 2'b00 : (m_age <= 2) ? 2'b01 : (t_bad ? 2'b11 : 2'b10);

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_active <= 1'b0; m_age <= 0; m_cyc_reg <= 1'b0; m_cnt <= '0;
            t_addr <= '0; t_data <= '0; t_we <= 1'b0; t_tag <= 1'b0; t_bad <= 1'b0;
            t_sel <= '0; t_cti <= '0; exp_ack <= 1'b0; exp_err <= 1'b0; exp_data <= '0;
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
        end else begin
            exp_ack   <= 1'b0;
            exp_err   <= 1'b0;
            m_cyc_reg <= cyc_o;
            m_cnt     <= e_wcyc ? m_cnt + 5'(e_wack) : 5'd0;
            if (!m_active) begin
                if (stb_o) begin
                    m_active <= 1'b1; m_age <= 1;
                    t_addr <= addr_o; t_data <= data_o; t_we <= we_o; t_sel <= sel_o;
                    t_cti <= cti_input; t_tag <= tag_add;
                    t_bad <= (sel_o == 4'd0) || (cti_input >= 3'd3 && cti_input <= 3'd6);
                end
            end else begin
                if (m_age < 3) m_age <= m_age + 1;
                if (m_age == 1 && !t_bad && t_we) m_mem[t_addr] <= merge(m_mem[t_addr], t_data, t_sel);
                if (m_age == 2) begin
                    exp_ack <= !t_bad;
                    exp_err <= t_bad;
                    if (!t_bad && !t_we) exp_data <= m_mem[t_addr];
                end
                if (m_age >= 3 && !stb_o) m_active <= 1'b0;
            end
        end
    end

    // ---------------- Cycle-by-cycle compare ----------------
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("ack_i", 32'(ack_i), 32'(exp_ack));
            chk("err_i", 32'(err_i), 32'(exp_err));
            chk("ack_err_excl", 32'(ack_i & err_i), 32'(0));
            chk("data_i", data_i, exp_data);
            chk("state_out", 32'(state_out), 32'(e_state));
            chk("counter", 32'(counter), 32'(m_cnt));
            chk("w_stb", 32'(dbg_w_stb), 32'(e_wstb));
            chk("w_cyc", 32'(dbg_w_cyc), 32'(e_wcyc));
            chk("w_ack", 32'(dbg_w_ack), 32'(e_wack));
            chk("w_err", 32'(dbg_w_err), 32'(e_werr));
            if (m_active) begin
                chk("w_addr", 32'(dbg_w_addr), 32'(t_addr));
                chk("w_data_m2s", dbg_w_data_m2s, t_data);
                chk("w_we", 32'(dbg_w_we), 32'(t_we));
                chk("w_sel", 32'(dbg_w_sel), 32'(t_sel));
                chk("cti", 32'(dbg_cti), 32'(t_cti));
                chk("tag", 32'(dbg_tag_add), 32'(t_tag));
            end
            if (exp_ack && !t_we) chk("w_data_s2m", dbg_w_data_s2m, exp_data);
        end
    end

    // ---------------- Stimulus ----------------
    int acks, errs, first_ack, st3;

    task automatic xfer(input logic [4:0] a, input logic [31:0] d, input logic we,
                        input logic [3:0] s, input logic [2:0] cti, input logic tag,
                        input logic cyc, input int hold);
        @(negedge clk_i);
        addr_o = a; data_o = d; we_o = we; sel_o = s; cti_input = cti;
        tag_add = tag; cyc_o = cyc; stb_o = 1'b1;
        acks = 0; errs = 0; first_ack = 0; st3 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                chk("xfer_addr", 32'(dbg_w_addr), 32'(a));
                chk("xfer_tag", 32'(dbg_tag_add), 32'(tag));
            end
            if (ack_i) begin
                acks++;
                if (first_ack == 0) first_ack = i;
            end
            if (err_i) errs++;
            if (i == 3) st3 = int'(state_out);
            if (i == hold) stb_o = 1'b0;
            if (i >= 3 && state_out == 2'b00 && !stb_o) break;
        end
        chk("xfer_idle", 32'(state_out), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0; addr_o = '0; data_o = '0; we_o = 1'b0; stb_o = 1'b0;
        cyc_o = 1'b0; sel_o = '0; cti_input = '0; tag_add = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 32'(ack_i), 32'(0));
        chk("rst_state", 32'(state_out), 32'(0));
        chk("rst_counter", 32'(counter), 32'(0));
        chk("rst_data", data_i, 32'h0);
        chk("rst_cyc", 32'(dbg_w_cyc), 32'(0));
        rst_i = 1'b1;

        // Write 0x1111 to addr 0, stb held two cycles
        xfer(5'd0, 32'h0000_1111, 1'b1, 4'hF, 3'b001, 1'b0, 1'b1, 2);
        chk("t1_acks", 32'(acks), 32'd1);
        chk("t1_ack_time", 32'(first_ack), 32'd3);
        chk("t1_counter", 32'(counter), 32'd1);

        // Two more writes in the same bus cycle
        xfer(5'd1, 32'h0000_2222, 1'b1, 4'hF, 3'b010, 1'b0, 1'b1, 1);
        chk("t2a_acks", 32'(acks), 32'd1);
        xfer(5'd20, 32'h0000_2222, 1'b1, 4'hF, 3'b010, 1'b0, 1'b1, 1);
        chk("t2b_acks", 32'(acks), 32'd1);
        chk("t2_counter", 32'(counter), 32'd3);

        // Tagged read of an unwritten word, then end the burst
        xfer(5'd2, 32'h0, 1'b0, 4'hF, 3'b010, 1'b1, 1'b1, 1);
        chk("t3_data", data_i, 32'h0);
        chk("t3_acks", 32'(acks), 32'd1);
        chk("t3_counter", 32'(counter), 32'd4);
        @(negedge clk_i); cti_input = 3'b111; cyc_o = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t3_counter_clr", 32'(counter), 32'd0);

        // Read-back and partial byte write
        xfer(5'd1, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t4_rd1", data_i, 32'h0000_2222);
        xfer(5'd3, 32'hAABB_CCDD, 1'b1, 4'b0001, 3'b000, 1'b0, 1'b0, 1);
        xfer(5'd3, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t4_rd3", data_i, 32'h0000_00DD);

        // Error cases: sel=0 and reserved cti
        xfer(5'd5, 32'hDEAD_BEEF, 1'b1, 4'h0, 3'b000, 1'b0, 1'b0, 1);
        chk("t5a_errs", 32'(errs), 32'd1);
        chk("t5a_acks", 32'(acks), 32'd0);
        chk("t5a_state", 32'(st3), 32'd3);
        xfer(5'd0, 32'h5555_5555, 1'b1, 4'hF, 3'b011, 1'b0, 1'b0, 1);
        chk("t5b_errs", 32'(errs), 32'd1);
        xfer(5'd5, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t5_rd5", data_i, 32'h0);
        xfer(5'd0, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t5_rd0", data_i, 32'h0000_1111);

        // Long strobe: still a single transfer
        xfer(5'd7, 32'h0000_0077, 1'b1, 4'hF, 3'b000, 1'b0, 1'b1, 6);
        chk("t6_acks", 32'(acks), 32'd1);

        // Reset while BUSY
        @(negedge clk_i);
        addr_o = 5'd6; data_o = 32'h66; we_o = 1'b1; sel_o = 4'hF; cti_input = 3'b000;
        cyc_o = 1'b1; stb_o = 1'b1;
        @(negedge clk_i);
        chk("t7_busy", 32'(state_out), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("t7_state", 32'(state_out), 32'd0);
        chk("t7_stb", 32'(dbg_w_stb), 32'd0);
        chk("t7_cyc", 32'(dbg_w_cyc), 32'd0);
        chk("t7_ack", 32'(ack_i), 32'd0);
        chk("t7_counter", 32'(counter), 32'd0);
        chk("t7_data", data_i, 32'h0);
        @(negedge clk_i);
        stb_o = 1'b0; cyc_o = 1'b0;
        rst_i = 1'b1;
        xfer(5'd0, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t7_rd0", data_i, 32'h0);
        xfer(5'd7, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t7_rd7", data_i, 32'h0);
        xfer(5'd6, 32'h0, 1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 1);
        chk("t7_rd6", data_i, 32'h0);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
